// File: rtl/ram_burst_writer.sv
// Burst writer: accepts a valid/ready word stream and writes it into an internal
// RAM from a programmable base address, wrapping at the top; async read port.
module ram_burst_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   wr_count,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_q
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
   logic [ADDR_WIDTH:0]   wr_count_nxt;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      remaining_nxt = remaining;
      wr_count_nxt  = wr_count;
      wr_en         = 1'b0;
      in_ready      = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               wr_count_nxt = '0;
               if (len != '0) begin
                  wr_ptr_nxt    = base_addr;
                  remaining_nxt = len;
                  state_nxt     = WRITE;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         WRITE: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               wr_en         = 1'b1;
               wr_ptr_nxt    = wr_ptr + ADDR_WIDTH'(1);
               remaining_nxt = remaining - (ADDR_WIDTH+1)'(1);
               wr_count_nxt  = wr_count + (ADDR_WIDTH+1)'(1);
               if (remaining == (ADDR_WIDTH+1)'(1))
                  state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         remaining <= '0;
         wr_count  <= '0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         remaining <= remaining_nxt;
         wr_count  <= wr_count_nxt;
      end
   end

   // Memory is never cleared; a reset edge suppresses the write it would abort.
   always_ff @(posedge clk) begin
      if (wr_en && rst_n)
         mem[wr_ptr] <= in_data;
   end

   assign rd_q = mem[rd_addr];

endmodule
